ef_i2s_tdm_rx: RTL and testbench

Master-mode multi-slot audio serial receiver. It generates the serial clock (sck) and word select/frame sync (ws) itself, and captures serial data (sd) in one of three formats: I2S, left-justified or TDM with up to NCH slots. Each enabled slot's sample is written into one shared FIFO as a sign/zero-extended word tagged with its slot number. It sits between the pad-level audio interface and the bus wrapper, and is the multi-slot, parametrised successor of the two-channel I2S receiver.

---
 rtl/ef_i2s_tdm_rx.sv | 151 +++++++++++++++
 tb/tb_ef_i2s_tdm_rx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ef_i2s_tdm_rx.sv
// Master-mode I2S / left-justified / TDM receiver: drives sck/ws, deserialises sd into a slot-tagged FWFT FIFO.
// Sample is written on the clk of its last capture rise; no backpressure, a full FIFO drops the sample and flags overrun.
module ef_i2s_tdm_rx #(
  parameter int DW  = 32,
  parameter int AW  = 4,
  parameter int NCH = 8,
  parameter int CW  = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    fmt,
  input  logic [CW-1:0] num_slots,
  input  logic [5:0]    slot_size,
  input  logic [5:0]    sample_size,
  input  logic [7:0]    sck_prescaler,
  input  logic [NCH-1:0] slot_en,
  input  logic          sign_extend,
  output logic          sck,
  output logic          ws,
  input  logic          sd,
  input  logic          fifo_rd,
  input  logic          fifo_clr,
  input  logic [AW:0]   fifo_threshold,
  output logic [DW-1:0] fifo_rdata,
  output logic [CW-1:0] fifo_rslot,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic [AW:0]   fifo_level,
  output logic          fifo_level_above,
  output logic          overrun
);
  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE   = (AW+1)'(1);

  logic [7:0]    presc;
  logic [5:0]    bit_ctr, bit_nxt, cap_cnt, d;
  logic [CW-1:0] slot_ctr, slot_nxt, slot_last, cap_slot, wr_slot;
  logic          cap_act, tdm, tick, rise, fall, start, done, wr, sgn;
  logic [DW-1:0] shreg, raw, ext;

  assign tdm       = fmt[1];
  assign d         = (fmt == 2'b00) ? 6'd1 : 6'd0;
  assign slot_last = tdm ? num_slots : CW'(1);
  assign tick      = en && (presc == 8'd0);
  assign rise      = tick && !sck;
  assign fall      = tick && sck;
  assign start     = rise && (bit_ctr == d);
  // A window that starts and ends on the same rise is the 1-bit sample case.
  assign done      = rise && (start ? (sample_size == 6'd0) : (cap_act && cap_cnt == 6'd1));
  assign raw       = start ? DW'(sd) : {shreg[DW-2:0], sd};
  assign wr_slot   = start ? slot_ctr : cap_slot;
  assign wr        = done && slot_en[wr_slot];

  always_comb begin
    bit_nxt  = bit_ctr + 6'd1;
    slot_nxt = slot_ctr;
    if (bit_ctr == slot_size) begin
      bit_nxt  = 6'd0;
      slot_nxt = (slot_ctr == slot_last) ? '0 : slot_ctr + CW'(1);
    end
  end

  always_comb begin
    sgn = 1'b0;
    for (int i = 0; i < DW; i++)
      if (i == int'(sample_size)) sgn = raw[i];
    ext = '0;
    for (int i = 0; i < DW; i++)
      ext[i] = (i <= int'(sample_size)) ? raw[i] : (sign_extend & sgn);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      sck      <= 1'b0;
      ws       <= 1'b0;
      bit_ctr  <= '0;
      slot_ctr <= '0;
      cap_act  <= 1'b0;
      cap_cnt  <= '0;
      cap_slot <= '0;
      shreg    <= '0;
    end else if (!en) begin
      // Preloading the reload value puts the first rise sck_prescaler+1 clk after enable.
      presc    <= sck_prescaler;
      sck      <= 1'b0;
      ws       <= tdm;
      bit_ctr  <= '0;
      slot_ctr <= '0;
      cap_act  <= 1'b0;
      cap_cnt  <= '0;
      cap_slot <= '0;
      shreg    <= '0;
    end else begin
      presc <= tick ? sck_prescaler : presc - 8'd1;
      if (tick) sck <= !sck;
      if (fall) begin
        bit_ctr  <= bit_nxt;
        slot_ctr <= slot_nxt;
        ws       <= tdm ? (slot_nxt == '0 && bit_nxt == 6'd0) : (slot_nxt == CW'(1));
      end
      if (start) begin
        shreg    <= raw;
        cap_slot <= slot_ctr;
        cap_act  <= (sample_size != 6'd0);
        cap_cnt  <= sample_size;
      end else if (rise && cap_act) begin
        shreg   <= raw;
        cap_cnt <= cap_cnt - 6'd1;
        if (cap_cnt == 6'd1) cap_act <= 1'b0;
      end
    end
  end

  logic [DW+CW-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             wr_ok, rd_ok;

  assign fifo_empty       = (fifo_level == '0);
  assign fifo_full        = (fifo_level == DEPTH_LVL);
  assign fifo_level_above = (fifo_level > fifo_threshold);
  assign wr_ok            = wr && !fifo_full && !fifo_clr;
  assign rd_ok            = fifo_rd && !fifo_empty && !fifo_clr;
  assign {fifo_rslot, fifo_rdata} = fifo_empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= {wr_slot, ext};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      overrun    <= 1'b0;
    end else if (fifo_clr) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      overrun    <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) rptr <= rptr + AW'(1);
      if (wr_ok && !rd_ok) fifo_level <= fifo_level + LVL_ONE;
      else if (rd_ok && !wr_ok) fifo_level <= fifo_level - LVL_ONE;
      if (wr && fifo_full) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ef_i2s_tdm_rx.sv
// Directed bench for ef_i2s_tdm_rx: a codec model streams per-format frames, FIFO contents checked against a table.
module tb_ef_i2s_tdm_rx;
  localparam int DW = 32, AW = 2, NCH = 8, CW = 3;

  logic clk = 1'b0;
  logic rst, en, sign_extend, sck, ws, sd, fifo_rd, fifo_clr;
  logic fifo_empty, fifo_full, fifo_level_above, overrun;
  logic [1:0] fmt;
  logic [CW-1:0] num_slots, fifo_rslot;
  logic [5:0] slot_size, sample_size;
  logic [7:0] sck_prescaler;
  logic [NCH-1:0] slot_en;
  logic [AW:0] fifo_threshold, fifo_level;
  logic [DW-1:0] fifo_rdata;

  always #5 clk = ~clk;

  ef_i2s_tdm_rx #(.DW(DW), .AW(AW), .NCH(NCH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .fmt(fmt), .num_slots(num_slots),
    .slot_size(slot_size), .sample_size(sample_size), .sck_prescaler(sck_prescaler),
    .slot_en(slot_en), .sign_extend(sign_extend), .sck(sck), .ws(ws), .sd(sd),
    .fifo_rd(fifo_rd), .fifo_clr(fifo_clr), .fifo_threshold(fifo_threshold),
    .fifo_rdata(fifo_rdata), .fifo_rslot(fifo_rslot), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_level(fifo_level), .fifo_level_above(fifo_level_above),
    .overrun(overrun)
  );

  typedef struct {
    logic [1:0]       fmt;
    logic [2:0]       nslots;
    logic [5:0]       ssz, smp;
    logic             sext;
    logic [7:0]       presc, sen;
    logic [7:0][31:0] data;
    int               nexp;
    logic [3:0][31:0] edat;
    logic [3:0][2:0]  eslot;
    int               ws_hi;
  } vec_t;

  int tests = 0, fails = 0, cyc = 0;
  vec_t tv[5];
  vec_t v_ovr, v_dis;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] f, input logic [2:0] ns, input logic [5:0] ss,
                              input logic [5:0] sm, input logic sx, input logic [7:0] p,
                              input logic [7:0] se, input int ne, input int wh);
    vec_t v;
    v = '{default: '0};
    v.fmt = f; v.nslots = ns; v.ssz = ss; v.smp = sm; v.sext = sx;
    v.presc = p; v.sen = se; v.nexp = ne; v.ws_hi = wh;
    return v;
  endfunction

  // Bit on sd during the k-th sck high phase of a frame; bits outside the window carry 1s.
  function automatic logic sbit(input vec_t v, input int k, input int d, input int s_cnt);
    int g, s, p;
    g = k - d;
    if (g < 0) return 1'b1;
    s = (g / (int'(v.ssz) + 1)) % s_cnt;
    p = g % (int'(v.ssz) + 1);
    if (p <= int'(v.smp)) return v.data[s][int'(v.smp) - p];
    return 1'b1;
  endfunction

  task automatic next_fall();
    int n;
    bit hi;
    n = 0; hi = 0;
    while (n < 1000) begin
      @(negedge clk); n++; cyc++;
      if (sck) hi = 1;
      else if (hi) return;
    end
    tests++; fails++;
    $display("FAIL sck_timeout: no sck fall within 1000 clk");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  task automatic set_cfg(input vec_t v);
    fmt = v.fmt; num_slots = v.nslots; slot_size = v.ssz; sample_size = v.smp;
    sign_extend = v.sext; sck_prescaler = v.presc; slot_en = v.sen;
  endtask

  task automatic run_stream(input vec_t v);
    int d, s_cnt, n_ph, wshi;
    set_cfg(v);
    d = (v.fmt == 2'b00) ? 1 : 0;
    s_cnt = v.fmt[1] ? int'(v.nslots) + 1 : 2;
    n_ph = s_cnt * (int'(v.ssz) + 1) + d;
    @(negedge clk);
    sd = sbit(v, 0, d, s_cnt);
    wshi = int'(ws);
    cyc = 0;
    en = 1'b1;
    for (int k = 1; k < n_ph; k++) begin
      next_fall();
      sd = sbit(v, k, d, s_cnt);
      wshi += int'(ws);
    end
    chk("sck_timing", cyc, 2 * (n_ph - 1) * (int'(v.presc) + 1));
    chk("ws_high_phases", wshi, v.ws_hi);
    repeat (int'(v.presc) + 2) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("idle_sck", sck, 0);
    chk("idle_ws", ws, v.fmt[1]);
  endtask

  task automatic drain(input vec_t v);
    chk("level", fifo_level, v.nexp);
    for (int i = 0; i < v.nexp; i++) begin
      chk("rdata", fifo_rdata, v.edat[i]);
      chk("rslot", fifo_rslot, v.eslot[i]);
      fifo_rd = 1'b1; @(negedge clk); fifo_rd = 1'b0;
    end
    chk("empty_after_drain", fifo_empty, 1);
  endtask

  task automatic pulse_clr();
    fifo_clr = 1'b1; @(negedge clk); fifo_clr = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sck"}, sck, 0);
    chk({tag, "_ws"}, ws, 0);
    chk({tag, "_empty"}, fifo_empty, 1);
    chk({tag, "_full"}, fifo_full, 0);
    chk({tag, "_level"}, fifo_level, 0);
    chk({tag, "_above"}, fifo_level_above, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_rdata"}, fifo_rdata, 0);
    chk({tag, "_rslot"}, fifo_rslot, 0);
  endtask

  initial begin
    // LJ, 2 slots, 24-bit signed in 32-bit slots, sck = 4 clk
    tv[0] = mk(2'b01, 3'd0, 6'd31, 6'd23, 1'b1, 8'd1, 8'hFF, 2, 32);
    tv[0].data[0] = 32'h800001; tv[0].data[1] = 32'h123456;
    tv[0].edat[0] = 32'hFF800001; tv[0].eslot[0] = 3'd0;
    tv[0].edat[1] = 32'h00123456; tv[0].eslot[1] = 3'd1;
    // I2S, full-slot samples, LSB lands on bit 0 of the next slot
    tv[1] = mk(2'b00, 3'd0, 6'd15, 6'd15, 1'b0, 8'd0, 8'hFF, 2, 16);
    tv[1].data[0] = 32'hA5A5; tv[1].data[1] = 32'h5A5A;
    tv[1].edat[0] = 32'h0000A5A5; tv[1].eslot[0] = 3'd0;
    tv[1].edat[1] = 32'h00005A5A; tv[1].eslot[1] = 3'd1;
    // TDM 4 slots, only slots 1 and 3 enabled
    tv[2] = mk(2'b10, 3'd3, 6'd15, 6'd15, 1'b0, 8'd0, 8'b0000_1010, 2, 1);
    tv[2].data[0] = 32'h1111; tv[2].data[1] = 32'h2222;
    tv[2].data[2] = 32'h3333; tv[2].data[3] = 32'h4444;
    tv[2].edat[0] = 32'h2222; tv[2].eslot[0] = 3'd1;
    tv[2].edat[1] = 32'h4444; tv[2].eslot[1] = 3'd3;
    // Reserved fmt acts as TDM: 3 slots, 4-bit signed samples in 8-bit slots
    tv[3] = mk(2'b11, 3'd2, 6'd7, 6'd3, 1'b1, 8'd2, 8'hFF, 3, 1);
    tv[3].data[0] = 32'h8; tv[3].data[1] = 32'h7; tv[3].data[2] = 32'hF;
    tv[3].edat[0] = 32'hFFFFFFF8; tv[3].eslot[0] = 3'd0;
    tv[3].edat[1] = 32'h00000007; tv[3].eslot[1] = 3'd1;
    tv[3].edat[2] = 32'hFFFFFFFF; tv[3].eslot[2] = 3'd2;
    // I2S, 12-bit signed sample in 16-bit slot
    tv[4] = mk(2'b00, 3'd0, 6'd15, 6'd11, 1'b1, 8'd1, 8'hFF, 2, 16);
    tv[4].data[0] = 32'h800; tv[4].data[1] = 32'h7FF;
    tv[4].edat[0] = 32'hFFFFF800; tv[4].eslot[0] = 3'd0;
    tv[4].edat[1] = 32'h000007FF; tv[4].eslot[1] = 3'd1;

    v_ovr = mk(2'b10, 3'd5, 6'd7, 6'd7, 1'b0, 8'd0, 8'hFF, 4, 1);
    for (int i = 0; i < 6; i++) v_ovr.data[i] = 32'h11 * (i + 1);

    v_dis = mk(2'b01, 3'd0, 6'd15, 6'd15, 1'b0, 8'd1, 8'hFF, 2, 16);
    v_dis.data[0] = 32'hBEEF; v_dis.data[1] = 32'h1234;
    v_dis.edat[0] = 32'h0000BEEF; v_dis.eslot[0] = 3'd0;
    v_dis.edat[1] = 32'h00001234; v_dis.eslot[1] = 3'd1;

    rst = 1'b1; en = 1'b0; fmt = 2'b01; num_slots = '0; slot_size = '0; sample_size = '0;
    sck_prescaler = '0; slot_en = '0; sign_extend = 1'b0; sd = 1'b0;
    fifo_rd = 1'b0; fifo_clr = 1'b0; fifo_threshold = 3'd2;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 5; t++) begin
      run_stream(tv[t]);
      drain(tv[t]);
      pulse_clr();
    end

    // Overrun: six samples into a four-deep FIFO with no reads
    run_stream(v_ovr);
    chk("ovr_level", fifo_level, 4);
    chk("ovr_full", fifo_full, 1);
    chk("ovr_flag", overrun, 1);
    chk("ovr_above", fifo_level_above, 1);
    chk("ovr_head", fifo_rdata, 32'h11);
    chk("ovr_head_slot", fifo_rslot, 0);
    pulse_clr();
    chk("clr_level", fifo_level, 0);
    chk("clr_overrun", overrun, 0);
    chk("clr_empty", fifo_empty, 1);
    chk("clr_full", fifo_full, 0);

    // Mid-frame disable at slot 0 bit 10, then a clean frame after re-enable
    set_cfg(v_dis);
    @(negedge clk);
    sd = 1'b1; cyc = 0; en = 1'b1;
    for (int k = 0; k < 10; k++) next_fall();
    repeat (2) @(negedge clk);
    chk("dis_sck_high", sck, 1);
    en = 1'b0;
    @(negedge clk);
    chk("dis_sck_low", sck, 0);
    repeat (4) @(negedge clk);
    chk("dis_no_write", fifo_level, 0);
    run_stream(v_dis);
    drain(v_dis);
    pulse_clr();

    // Synchronous reset while running with three words queued
    run_stream(tv[3]);
    chk("pre_rst_level", fifo_level, 3);
    chk("pre_rst_above", fifo_level_above, 1);
    en = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("sync_rst");
    rst = 1'b0; en = 1'b0;
    @(negedge clk);

    // Threshold boundary: level 2 is not above threshold 2
    run_stream(tv[3]);
    chk("thr_level3_above", fifo_level_above, 1);
    fifo_rd = 1'b1; @(negedge clk); fifo_rd = 1'b0;
    chk("thr_level2", fifo_level, 2);
    chk("thr_level2_above", fifo_level_above, 0);
    chk("thr_head_after_pop", fifo_rdata, 32'h00000007);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: bench did not complete within time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end
endmodule
